// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light front end: request-state encoding
// and default timing constants.
package traffic_pkg;

  typedef enum logic [2:0] {
    REQ_IDLE   = 3'b001,
    REQ_PEND   = 3'b010,
    REQ_SERVED = 3'b100
  } req_state_t;

  localparam int unsigned CLK_DIV_DEF   = 100_000_000;
  localparam int unsigned DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= stable;
      // Any return to the accepted level before the limit discards the glitch.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: tick divider plus two independent button
// channels with 4-phase req/ack handshake. Optional LED blink: PED_BLINK_EN.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ns,
  input  logic btn_we,
  input  logic ack_ns,
  input  logic ack_we,
  output logic tick,
  output logic req_ns,
  output logic req_we,
  output logic pend_led_ns,
  output logic pend_led_we
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Handshake: req rises on an accepted press and is held until ack is seen
  // high; the sequencer holds ack until it sees req low, and a new request is
  // only accepted once ack has been seen low again.
  logic [TW-1:0] div_cnt;
  logic [1:0]    press;
  logic [1:0]    ack;
  logic [1:0]    req_q;
  logic [1:0]    led_q;
  req_state_t    state_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == TW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == TW'(CLK_DIV - 1));

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ns (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ns),
    .press (press[0])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_we (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_we),
    .press (press[1])
  );

  assign ack = {ack_we, ack_ns};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= REQ_IDLE;
        req_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          REQ_IDLE: begin
            if (press[i]) begin
              state_q[i] <= REQ_PEND;
              req_q[i]   <= 1'b1;
            end
          end
          // Ack takes priority; a press arriving with it is lost.
          REQ_PEND: begin
            if (ack[i]) begin
              state_q[i] <= REQ_SERVED;
              req_q[i]   <= 1'b0;
            end
          end
          REQ_SERVED: begin
            if (!ack[i]) state_q[i] <= REQ_IDLE;
          end
          default: begin
            state_q[i] <= REQ_IDLE;
            req_q[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PED_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          REQ_IDLE: led_q[i] <= press[i];
          REQ_PEND: begin
            if (ack[i])    led_q[i] <= 1'b0;
            else if (tick) led_q[i] <= ~led_q[i];
          end
          default:  led_q[i] <= 1'b0;
        endcase
      end
    end
  end
`else
  assign led_q = req_q;
`endif

  assign req_ns      = req_q[0];
  assign req_we      = req_q[1];
  assign pend_led_ns = led_q[0];
  assign pend_led_we = led_q[1];

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl with CLK_DIV=10, DB_CYCLES=4; inputs
// change 1 time unit after a rising edge, outputs are checked there too.
module tb_ped_request_ctrl;

  logic clk;
  logic rst;
  logic btn_ns;
  logic btn_we;
  logic ack_ns;
  logic ack_we;
  logic tick;
  logic req_ns;
  logic req_we;
  logic pend_led_ns;
  logic pend_led_we;

  int checks;
  int errors;
  logic exp_led;
  logic prev_led;
  logic prev_tick;

  ped_request_ctrl #(.CLK_DIV(10), .DB_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_ns      (btn_ns),
    .btn_we      (btn_we),
    .ack_ns      (ack_ns),
    .ack_we      (ack_we),
    .tick        (tick),
    .req_ns      (req_ns),
    .req_we      (req_we),
    .pend_led_ns (pend_led_ns),
    .pend_led_we (pend_led_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    btn_ns = 1'b0;
    btn_we = 1'b0;
    ack_ns = 1'b0;
    ack_we = 1'b0;

    // Reset values
    step(3);
    chk("rst_tick", tick, 1'b0);
    chk("rst_req_ns", req_ns, 1'b0);
    chk("rst_req_we", req_we, 1'b0);
    chk("rst_led_ns", pend_led_ns, 1'b0);
    chk("rst_led_we", pend_led_we, 1'b0);
    rst = 1'b0;

    // Idle 35 cycles: tick in cycles 9, 19, 29 only
    for (int k = 0; k < 35; k++) begin
      chk("idle_tick", tick, (k % 10) == 9);
      chk("idle_req_ns", req_ns, 1'b0);
      chk("idle_req_we", req_we, 1'b0);
      step(1);
    end
    chk("idle_led_ns", pend_led_ns, 1'b0);
    chk("idle_led_we", pend_led_we, 1'b0);

    // NS press: req_ns rises after the 7th edge
    btn_ns = 1'b1;
    step(6);
    chk("ns_lat_early", req_ns, 1'b0);
    step(1);
    chk("ns_lat_rise", req_ns, 1'b1);
    chk("ns_led_entry", pend_led_ns, 1'b1);
    for (int k = 0; k < 50; k++) begin
      prev_led  = pend_led_ns;
      prev_tick = tick;
      step(1);
      chk("ns_hold_req", req_ns, 1'b1);
      chk("ns_hold_req_we", req_we, 1'b0);
`ifdef PED_BLINK_EN
      exp_led = prev_tick ? ~prev_led : prev_led;
`else
      exp_led = 1'b1;
`endif
      chk("ns_hold_led", pend_led_ns, exp_led);
    end

    // WE glitches of 2 cycles are rejected
    for (int k = 0; k < 6; k++) begin
      btn_we = 1'b1;
      step(2);
      btn_we = 1'b0;
      step(2);
      chk("we_glitch", req_we, 1'b0);
    end
    btn_we = 1'b1;
    step(6);
    chk("we_lat_early", req_we, 1'b0);
    step(1);
    chk("we_lat_rise", req_we, 1'b1);
    chk("we_led_entry", pend_led_we, 1'b1);

    // NS ack clears req after the sampling edge
    ack_ns = 1'b1;
    step(1);
    chk("ns_ack_clear", req_ns, 1'b0);
    chk("ns_ack_led", pend_led_ns, 1'b0);
    chk("ns_ack_we_kept", req_we, 1'b1);
    btn_ns = 1'b0;
    step(8);
    chk("ns_served_rel", req_ns, 1'b0);
    // Press while ack still held is dropped
    btn_ns = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("ns_served_press", req_ns, 1'b0);
    end
    ack_ns = 1'b0;
    step(1);
    chk("ns_ack_drop", req_ns, 1'b0);
    step(3);
    chk("ns_no_relevel", req_ns, 1'b0);
    btn_ns = 1'b0;
    step(8);
    btn_ns = 1'b1;
    step(6);
    chk("ns_repress_early", req_ns, 1'b0);
    step(1);
    chk("ns_repress_rise", req_ns, 1'b1);

    // WE ack clears only req_we
    ack_we = 1'b1;
    step(1);
    chk("we_ack_clear", req_we, 1'b0);
    chk("we_ack_ns_kept", req_ns, 1'b1);
    ack_we = 1'b0;
    step(1);
    btn_we = 1'b0;
    step(8);
    chk("we_idle", req_we, 1'b0);

    // Return NS to idle, then press both together
    ack_ns = 1'b1;
    step(1);
    chk("ns_ack2_clear", req_ns, 1'b0);
    ack_ns = 1'b0;
    step(1);
    btn_ns = 1'b0;
    step(8);
    btn_ns = 1'b1;
    btn_we = 1'b1;
    step(6);
    chk("both_early_ns", req_ns, 1'b0);
    chk("both_early_we", req_we, 1'b0);
    step(1);
    chk("both_rise_ns", req_ns, 1'b1);
    chk("both_rise_we", req_we, 1'b1);
    ack_we = 1'b1;
    step(1);
    chk("both_ackwe_we", req_we, 1'b0);
    chk("both_ackwe_ns", req_ns, 1'b1);

    // Asynchronous reset while NS pending
    rst = 1'b1;
    #1;
    chk("async_rst_req_ns", req_ns, 1'b0);
    chk("async_rst_led_ns", pend_led_ns, 1'b0);
    chk("async_rst_tick", tick, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ped_request_ctrl.md
# ped_request_ctrl

Pedestrian-request front end sitting directly upstream of the traffic-light sequencer. It synchronises and debounces the two crosswalk push-buttons (NS and WE), latches each press as a request level, and runs a 4-phase req/ack handshake with the sequencer. It also generates the 1-second tick strobe that the sequencer and the waiting-indicator LEDs use.

## Interface
- CLK_DIV, 100000000: clock cycles per tick period (1 s at 100 MHz); ≥ 2.
- DB_CYCLES, 1000000: cycles a synchronised button level must stay stable before it is accepted (10 ms); ≥ 2.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_ns  in  1  raw NS crosswalk button, asynchronous, active-high.
- btn_we  in  1  raw WE crosswalk button, asynchronous, active-high.
- ack_ns  in  1  sequencer acknowledge for the NS request, level.
- ack_we  in  1  sequencer acknowledge for the WE request, level.
- tick  out  1  one-cycle strobe every CLK_DIV cycles.
- req_ns  out  1  NS request pending, level.
- req_we  out  1  WE request pending, level.
- pend_led_ns  out  1  NS "WAIT" indicator.
- pend_led_we  out  1  WE "WAIT" indicator.

## Operation
- Tick: counter 0..CLK_DIV-1, wraps to 0; tick = 1 only while counter == CLK_DIV-1. Counter width = $clog2(CLK_DIV).
- Per channel: 2-flop synchroniser → debouncer → request FSM. The channels are independent, with no shared state except tick.
- Debouncer: holds `stable` (reset 0) and counter cnt (reset 0).
  - While sync2 == stable: cnt <= 0.
  - Otherwise, cnt increments each cycle. When cnt == DB_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Any return of sync2 to stable before the limit clears cnt, so glitches shorter than DB_CYCLES are discarded.
- press = stable & ~stable_d, giving one pulse per accepted rising edge. Releases generate nothing.
- Request FSM states and transitions:
  - IDLE: press → PEND. Ack is ignored.
  - PEND: req = 1. ack = 1 → SERVED. Further presses are absorbed (no queueing).
  - SERVED: req = 0. ack = 0 → IDLE. Presses are dropped.
- A press and an ack in the same PEND cycle: ack wins, the state goes to SERVED and the press is lost.
- The sequencer holds ack until it sees req low. This block holds req until it sees ack high.

## Timing
- Reset values: tick = 0, req_* = 0, pend_led_* = 0. All FSMs in IDLE, all counters 0, synchronisers and stable cleared.
- Reset mid-operation (e.g. in PEND) drops the pending request immediately and asynchronously.
- First tick is high during cycle CLK_DIV-1 after reset release, then every CLK_DIV cycles.
- Button latency: raw btn high and clean before edge 0 gives req high after edge 3+DB_CYCLES.
  - Edges 1–2: synchroniser.
  - Edge 2+DB_CYCLES: stable rises.
  - Next edge: FSM registers the press.
- Handshake: ack sampled high at edge n gives req low after edge n. ack sampled low in SERVED gives IDLE after that edge. A new press is accepted from the following cycle.
- req and pend_led are registered outputs with no combinational path from inputs.

## Configuration
- PED_BLINK_EN defined:
  - pend_led_x is set to 1 on entry to PEND and toggles on every tick while in PEND.
  - It is forced to 0 in IDLE and SERVED.
- PED_BLINK_EN undefined: pend_led_x is a registered copy of the request level, i.e. equal to req_x. The blink toggle flop is not built.

## Structure
- Shared package traffic_pkg holds:
  - Request-state encoding: REQ_IDLE, REQ_PEND, REQ_SERVED (one-hot, 3 bits).
  - Default CLK_DIV and DB_CYCLES constants.
- Sub-module btn_debounce (synchroniser + debouncer + press pulse, parameter DB_CYCLES) is instantiated twice.
- The tick counter and both request FSMs live in the top module.

## Test plan
Benches run with CLK_DIV=10, DB_CYCLES=4.
- Reset, then idle 35 cycles → all outputs 0 except tick, which pulses in cycles 9, 19, 29 after release.
- btn_ns held high from edge 0 → req_ns rises after edge 7 and stays 1 for 50 cycles with ack_ns = 0. req_we stays 0.
- btn_we toggling with 2-cycle high/low, 6 times → req_we stays 0. Then held high → req_we rises 7 edges later.
- req_ns = 1, ack_ns raised → req_ns = 0 after that edge. A press while ack is held 10 cycles → req_ns stays 0. Drop ack, press again → req_ns = 1 after 7 edges.
- Both buttons pressed in the same cycle → both req rise in the same cycle. ack_we only clears req_we. Assert rst while req_ns = 1 → req_ns and pend_led_ns go to 0 immediately.
- With PED_BLINK_EN, pending NS → pend_led_ns = 1, then toggles on each tick. Without the macro → pend_led_ns tracks req_ns exactly.
